// File: rtl/axi_lite_pkg.sv
// Shared AXI-lite response codes and the write/read FSM state encodings
// used by the 1-to-NUM_M bus demux.
package axi_lite_pkg;

  localparam int RESP_OKAY   = 0;
  localparam int RESP_SLVERR = 2;
  localparam int RESP_DECERR = 3;

  // The *WAIT states hold the downstream response ready until the selected port answers.
  typedef enum logic [1:0] {W_IDLE, W_FWD, W_BWAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_RWAIT, R_RESP} r_state_e;

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Address decoder: compares one address against NUM_M base/mask pairs and
// returns a one-hot port select, lowest index winning on overlap.
module axi_lite_addr_decode #(
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_M      = 4,
  parameter logic [NUM_M*ADDR_WIDTH-1:0] M_BASE = '0,
  parameter logic [NUM_M*ADDR_WIDTH-1:0] M_MASK = '0
)(
  input  logic [ADDR_WIDTH-1:0] addr_i,
  output logic [NUM_M-1:0]      hit_o,
  output logic                  miss_o
);

  logic [NUM_M-1:0] match;

  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_match
    assign match[gi] = (addr_i & M_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                       == M_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    logic found;
    found = 1'b0;
    hit_o = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (match[i] && !found) begin
        hit_o[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign miss_o = ~|match;

endmodule

// File: rtl/axi_lite_bus_demux.sv
// AXI-lite 1-to-NUM_M demux: one outstanding write and one outstanding read,
// each decoded, forwarded to a single downstream port and routed back.
module axi_lite_bus_demux
  import axi_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int RESP_WIDTH = 3,
  parameter int NUM_M      = 4,
  parameter logic [NUM_M*ADDR_WIDTH-1:0] M_BASE = {8'h30, 8'h20, 8'h10, 8'h00},
  parameter logic [NUM_M*ADDR_WIDTH-1:0] M_MASK = {8'hF0, 8'hF0, 8'hF0, 8'hF0}
)(
  input  logic                             axi_aclk,
  input  logic                             axi_areset,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_awaddr,
  input  logic                             s0_axi_awvalid,
  output logic                             s0_axi_awready,
  input  logic [DATA_WIDTH-1:0]            s0_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0]          s0_axi_wstrb,
  input  logic                             s0_axi_wvalid,
  output logic                             s0_axi_wready,
  output logic [RESP_WIDTH-1:0]            s0_axi_bresp,
  output logic                             s0_axi_bvalid,
  input  logic                             s0_axi_bready,
  input  logic [ADDR_WIDTH-1:0]            s0_axi_araddr,
  input  logic                             s0_axi_arvalid,
  output logic                             s0_axi_arready,
  output logic [DATA_WIDTH-1:0]            s0_axi_rdata,
  output logic [RESP_WIDTH-1:0]            s0_axi_rresp,
  output logic                             s0_axi_rvalid,
  input  logic                             s0_axi_rready,
  output logic [NUM_M*ADDR_WIDTH-1:0]      m_axi_awaddr,
  output logic [NUM_M-1:0]                 m_axi_awvalid,
  input  logic [NUM_M-1:0]                 m_axi_awready,
  output logic [NUM_M*DATA_WIDTH-1:0]      m_axi_wdata,
  output logic [NUM_M*DATA_WIDTH/8-1:0]    m_axi_wstrb,
  output logic [NUM_M-1:0]                 m_axi_wvalid,
  input  logic [NUM_M-1:0]                 m_axi_wready,
  input  logic [NUM_M*RESP_WIDTH-1:0]      m_axi_bresp,
  input  logic [NUM_M-1:0]                 m_axi_bvalid,
  output logic [NUM_M-1:0]                 m_axi_bready,
  output logic [NUM_M*ADDR_WIDTH-1:0]      m_axi_araddr,
  output logic [NUM_M-1:0]                 m_axi_arvalid,
  input  logic [NUM_M-1:0]                 m_axi_arready,
  input  logic [NUM_M*DATA_WIDTH-1:0]      m_axi_rdata,
  input  logic [NUM_M*RESP_WIDTH-1:0]      m_axi_rresp,
  input  logic [NUM_M-1:0]                 m_axi_rvalid,
  output logic [NUM_M-1:0]                 m_axi_rready
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  w_state_e                w_state_q, w_state_d;
  logic [NUM_M-1:0]        w_sel_q, w_sel_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
  logic                    aw_pend_q, aw_pend_d, w_pend_q, w_pend_d;
  logic [RESP_WIDTH-1:0]   bresp_q, bresp_d;

  r_state_e                r_state_q, r_state_d;
  logic [NUM_M-1:0]        r_sel_q, r_sel_d;
  logic [ADDR_WIDTH-1:0]   araddr_q, araddr_d;
  logic                    ar_pend_q, ar_pend_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [RESP_WIDTH-1:0]   rresp_q, rresp_d;

  logic [NUM_M-1:0]        aw_hit, ar_hit;
  logic                    aw_miss, ar_miss, w_accept, r_accept;
  logic [RESP_WIDTH-1:0]   m_bresp_sel, m_rresp_sel;
  logic [DATA_WIDTH-1:0]   m_rdata_sel;

  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_M(NUM_M), .M_BASE(M_BASE), .M_MASK(M_MASK))
    u_aw_decode (.addr_i(s0_axi_awaddr), .hit_o(aw_hit), .miss_o(aw_miss));
  axi_lite_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_M(NUM_M), .M_BASE(M_BASE), .M_MASK(M_MASK))
    u_ar_decode (.addr_i(s0_axi_araddr), .hit_o(ar_hit), .miss_o(ar_miss));

  // AW and W are only taken together so the write FSM never holds half a transaction.
  assign w_accept = (w_state_q == W_IDLE) && s0_axi_awvalid && s0_axi_wvalid && !axi_areset;
  assign r_accept = (r_state_q == R_IDLE) && s0_axi_arvalid && !axi_areset;

  assign s0_axi_awready = w_accept;
  assign s0_axi_wready  = w_accept;
  assign s0_axi_arready = r_accept;
  assign s0_axi_bvalid  = (w_state_q == W_RESP);
  assign s0_axi_bresp   = bresp_q;
  assign s0_axi_rvalid  = (r_state_q == R_RESP);
  assign s0_axi_rresp   = rresp_q;
  assign s0_axi_rdata   = rdata_q;

  always_comb begin
    m_bresp_sel = '0;
    m_rresp_sel = '0;
    m_rdata_sel = '0;
    for (int i = 0; i < NUM_M; i++) begin
      if (w_sel_q[i]) m_bresp_sel = m_bresp_sel | m_axi_bresp[i*RESP_WIDTH +: RESP_WIDTH];
      if (r_sel_q[i]) begin
        m_rresp_sel = m_rresp_sel | m_axi_rresp[i*RESP_WIDTH +: RESP_WIDTH];
        m_rdata_sel = m_rdata_sel | m_axi_rdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_sel_d   = w_sel_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: if (w_accept) begin
        awaddr_d = s0_axi_awaddr;
        wdata_d  = s0_axi_wdata;
        wstrb_d  = s0_axi_wstrb;
        if (aw_miss) begin
          bresp_d   = RESP_WIDTH'(RESP_DECERR);
          w_sel_d   = '0;
          w_state_d = W_RESP;
        end else begin
          w_sel_d   = aw_hit;
          aw_pend_d = 1'b1;
          w_pend_d  = 1'b1;
          w_state_d = W_FWD;
        end
      end
      W_FWD: begin
        if (|(m_axi_awready & w_sel_q)) aw_pend_d = 1'b0;
        if (|(m_axi_wready & w_sel_q))  w_pend_d  = 1'b0;
        if (!aw_pend_d && !w_pend_d)    w_state_d = W_BWAIT;
      end
      W_BWAIT: if (|(m_axi_bvalid & w_sel_q)) begin
        bresp_d   = m_bresp_sel;
        w_state_d = W_RESP;
      end
      W_RESP: if (s0_axi_bready) begin
        w_sel_d   = '0;
        w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_d = r_state_q;
    r_sel_d   = r_sel_q;
    araddr_d  = araddr_q;
    ar_pend_d = ar_pend_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: if (r_accept) begin
        araddr_d = s0_axi_araddr;
        if (ar_miss) begin
          rdata_d   = '0;
          rresp_d   = RESP_WIDTH'(RESP_DECERR);
          r_sel_d   = '0;
          r_state_d = R_RESP;
        end else begin
          r_sel_d   = ar_hit;
          ar_pend_d = 1'b1;
          r_state_d = R_FWD;
        end
      end
      R_FWD: if (|(m_axi_arready & r_sel_q)) begin
        ar_pend_d = 1'b0;
        r_state_d = R_RWAIT;
      end
      R_RWAIT: if (|(m_axi_rvalid & r_sel_q)) begin
        rdata_d   = m_rdata_sel;
        rresp_d   = m_rresp_sel;
        r_state_d = R_RESP;
      end
      R_RESP: if (s0_axi_rready) begin
        r_sel_d   = '0;
        r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      w_state_q <= W_IDLE;
      w_sel_q   <= '0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_sel_q   <= w_sel_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state_q <= R_IDLE;
      r_sel_q   <= '0;
      araddr_q  <= '0;
      ar_pend_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_sel_q   <= r_sel_d;
      araddr_q  <= araddr_d;
      ar_pend_q <= ar_pend_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  // Payload is zeroed on unselected ports so only the target ever sees the transaction.
  for (genvar gi = 0; gi < NUM_M; gi++) begin : g_port
    assign m_axi_awvalid[gi] = w_sel_q[gi] & aw_pend_q;
    assign m_axi_wvalid[gi]  = w_sel_q[gi] & w_pend_q;
    assign m_axi_bready[gi]  = w_sel_q[gi] & (w_state_q == W_BWAIT);
    assign m_axi_arvalid[gi] = r_sel_q[gi] & ar_pend_q;
    assign m_axi_rready[gi]  = r_sel_q[gi] & (r_state_q == R_RWAIT);
    assign m_axi_awaddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = w_sel_q[gi] ? awaddr_q : '0;
    assign m_axi_wdata[gi*DATA_WIDTH +: DATA_WIDTH]  = w_sel_q[gi] ? wdata_q : '0;
    assign m_axi_wstrb[gi*STRB_WIDTH +: STRB_WIDTH]  = w_sel_q[gi] ? wstrb_q : '0;
    assign m_axi_araddr[gi*ADDR_WIDTH +: ADDR_WIDTH] = r_sel_q[gi] ? araddr_q : '0;
  end

endmodule
